// File: rtl/wmem_loader.sv
// wmem_loader: packs IN_WIDTH beats into weight words and writes them to weights memory; optional beat checksum via WMEM_LOADER_CHECKSUM_EN
module wmem_loader #(
  parameter int DATA_WIDTH        = 8,
  parameter int NUM_MAC4          = 16,
  parameter int ADDR_WIDTH        = 7,
  parameter int IN_WIDTH          = 32,
  parameter int TOTAL_INPUT_WIDTH = NUM_MAC4*4*DATA_WIDTH,
  parameter int BEATS             = TOTAL_INPUT_WIDTH/IN_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_start,
  input  logic [ADDR_WIDTH-1:0]        in_base_addr,
  input  logic [ADDR_WIDTH:0]          in_num_words,
  input  logic                         in_valid,
  input  logic [IN_WIDTH-1:0]          in_data,
  output logic                         out_ready,
  output logic                         out_wr_en,
  output logic [ADDR_WIDTH-1:0]        out_wr_addr,
  output logic [TOTAL_INPUT_WIDTH-1:0] out_wr_data,
  output logic                         out_busy,
  output logic                         out_done,
  output logic [IN_WIDTH-1:0]          out_checksum
);
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
  state_t                       state;
  logic [CW-1:0]                cnt;
  logic [ADDR_WIDTH:0]          rem;
  logic [TOTAL_INPUT_WIDTH-1:0] buf_q, buf_d;
  logic                         acc, last;
  assign out_ready = state == LOAD;
  assign out_wr_en = state == WRITE;
  assign out_done  = state == DONE;
  assign out_busy  = state != IDLE;
  assign acc       = in_valid && out_ready;
  assign last      = cnt == CW'(BEATS-1);
  always_comb begin
    buf_d = buf_q;
    buf_d[int'(cnt)*IN_WIDTH +: IN_WIDTH] = in_data;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      buf_q       <= '0;
      out_wr_addr <= '0;
      out_wr_data <= '0;
    end else
      case (state)
        IDLE:
          if (in_start) begin
            out_wr_addr <= in_base_addr;
            rem         <= in_num_words;
            cnt         <= '0;
            state       <= in_num_words == '0 ? DONE : LOAD;
          end
        LOAD:
          if (acc) begin
            buf_q <= buf_d;
            cnt   <= cnt + 1'b1;
            if (last) begin
              out_wr_data <= buf_d;
              state       <= WRITE;
            end
          end
        WRITE: begin
          out_wr_addr <= out_wr_addr + 1'b1;
          rem         <= rem - 1'b1;
          cnt         <= '0;
          state       <= rem > (ADDR_WIDTH+1)'(1) ? LOAD : DONE;
        end
        default: state <= IDLE;
      endcase
`ifdef WMEM_LOADER_CHECKSUM_EN
  logic [IN_WIDTH-1:0] csum;
  always_ff @(posedge clk)
    if (rst) csum <= '0;
    else if (state == IDLE && in_start) csum <= '0;
    else if (acc) csum <= csum ^ in_data;
  assign out_checksum = csum;
`else
  assign out_checksum = '0;
`endif
endmodule

// File: tb/tb_wmem_loader.sv
// tb_wmem_loader: directed self-checking bench for wmem_loader
module tb_wmem_loader;
  localparam int AW = 7, IW = 32, TW = 512, NB = 16;
`ifdef WMEM_LOADER_CHECKSUM_EN
  localparam logic [IW-1:0] CS_POW = 32'h0000FFFF;
`else
  localparam logic [IW-1:0] CS_POW = 32'h0;
`endif
  logic          clk = 0, rst = 1, in_start = 0, in_valid = 0;
  logic [AW-1:0] in_base_addr = '0;
  logic [AW:0]   in_num_words = '0;
  logic [IW-1:0] in_data = '0;
  logic          out_ready, out_wr_en, out_busy, out_done;
  logic [AW-1:0] out_wr_addr;
  logic [TW-1:0] out_wr_data;
  logic [IW-1:0] out_checksum;
  int            n_assert = 0, n_fail = 0, wr_n = 0, cyc = 0, t0 = 0;
  logic [TW-1:0] exp_a, exp_b, exp_c;
  wmem_loader dut (
    .clk(clk), .rst(rst), .in_start(in_start), .in_base_addr(in_base_addr),
    .in_num_words(in_num_words), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr),
    .out_wr_data(out_wr_data), .out_busy(out_busy), .out_done(out_done),
    .out_checksum(out_checksum)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (out_wr_en) wr_n <= wr_n + 1;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [AW-1:0] b, input logic [AW:0] n);
    in_base_addr = b;
    in_num_words = n;
    in_start = 1;
    step;
    in_start = 0;
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_ready"}, out_ready, 0);
    check({tag, "_wr_en"}, out_wr_en, 0);
    check({tag, "_addr"}, out_wr_addr, 0);
    check({tag, "_data"}, out_wr_data, 0);
    check({tag, "_busy"}, out_busy, 0);
    check({tag, "_done"}, out_done, 0);
    check({tag, "_csum"}, out_checksum, 0);
  endtask
  initial begin
    for (int k = 0; k < NB; k++) begin
      exp_a[k*IW +: IW] = IW'(k);
      exp_c[k*IW +: IW] = IW'(1) << k;
    end
    repeat (2) step;
    check_reset("rst");
    rst = 0;
    start(5, 1);
    check("t1_ready", out_ready, 1);
    check("t1_busy", out_busy, 1);
    in_valid = 1;
    for (int k = 0; k < NB; k++) begin
      in_data = IW'(k);
      step;
    end
    in_valid = 0;
    check("t1_wr_en", out_wr_en, 1);
    check("t1_addr", out_wr_addr, 5);
    check("t1_data", out_wr_data, exp_a);
    check("t1_ready_wr", out_ready, 0);
    step;
    check("t1_done", out_done, 1);
    check("t1_wr_en_off", out_wr_en, 0);
    step;
    check("t1_busy_off", out_busy, 0);
    check("t1_done_off", out_done, 0);
    check("t1_csum", out_checksum, 0);
    check("t1_wr_n", wr_n, 1);
    start(127, 2);
    in_valid = 1;
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < NB; k++) begin
        in_data = 32'hA0000000 | (IW'(w) << 8) | IW'(k);
        exp_b[k*IW +: IW] = in_data;
        step;
      end
      check("t2_wr_en", out_wr_en, 1);
      check("t2_addr", out_wr_addr, w == 0 ? 7'd127 : 7'd0);
      check("t2_data", out_wr_data, exp_b);
      if (w == 0) t0 = cyc;
      else check("t2_gap", cyc - t0, 17);
      step;
      check("t2_ready_after", out_ready, w == 0);
    end
    in_valid = 0;
    check("t2_done", out_done, 1);
    step;
    check("t2_busy_off", out_busy, 0);
    check("t2_wr_n", wr_n, 3);
    start(10, 1);
    for (int i = 0; i < 2*NB - 1; i++) begin
      in_valid = i % 2 == 0;
      in_data = i % 2 == 0 ? IW'(i/2) : 32'hDEADBEEF;
      step;
    end
    in_valid = 0;
    check("t3_wr_en", out_wr_en, 1);
    check("t3_addr", out_wr_addr, 10);
    check("t3_data", out_wr_data, exp_a);
    step;
    check("t3_done", out_done, 1);
    step;
    start(3, 0);
    check("t4_done", out_done, 1);
    check("t4_ready", out_ready, 0);
    check("t4_busy", out_busy, 1);
    step;
    check("t4_done_off", out_done, 0);
    check("t4_busy_off", out_busy, 0);
    check("t4_wr_n", wr_n, 4);
    start(20, 1);
    in_valid = 1;
    for (int k = 0; k < 7; k++) begin
      in_data = 32'h5500 + IW'(k);
      step;
    end
    in_valid = 0;
    rst = 1;
    step;
    rst = 0;
    check_reset("t5_rst");
    check("t5_wr_n", wr_n, 4);
    start(40, 1);
    in_valid = 1;
    for (int k = 0; k < NB; k++) begin
      in_data = IW'(k);
      step;
    end
    in_valid = 0;
    check("t5_wr_en", out_wr_en, 1);
    check("t5_addr", out_wr_addr, 40);
    check("t5_data", out_wr_data, exp_a);
    step;
    check("t5_done", out_done, 1);
    step;
    start(50, 1);
    in_valid = 1;
    for (int k = 0; k < NB; k++) begin
      in_data = IW'(1) << k;
      in_start = k == 3;
      in_base_addr = k == 3 ? 7'd99 : 7'd50;
      in_num_words = k == 3 ? 8'd5 : 8'd1;
      step;
    end
    in_start = 0;
    in_valid = 0;
    check("t6_wr_en", out_wr_en, 1);
    check("t6_addr", out_wr_addr, 50);
    check("t6_data", out_wr_data, exp_c);
    step;
    check("t6_done", out_done, 1);
    step;
    check("t6_busy_off", out_busy, 0);
    check("t6_csum", out_checksum, CS_POW);
    repeat (2) step;
    check("t6_csum_hold", out_checksum, CS_POW);
    check("t6_wr_n", wr_n, 6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
